// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmitter with a run-time programmable bit period.
//
// Sends one DATA_WDTH-bit word per frame: a low start bit, the data LSB first,
// then STOP_BITS high stop bits. Every bit lasts bit_cyc = FREQ_CLK / baud
// clock cycles. The divisor is computed when the baud register is written and
// held in a pending register. It moves into the active register only when a
// word is accepted, so a frame never changes rate part way through.
//
// Ports
//   CLKip          in   1          clock, rising edge
//   RSTi           in   1          synchronous active-high reset
//   BAUD_RATEi     in   32         baud rate in bits/s
//   BAUD_RATE_WEi  in   1          write strobe for BAUD_RATEi
//   DATAi          in   DATA_WDTH  word to send
//   VALIDi         in   1          DATAi valid
//   READYo         out  1          transmitter can accept a word
//   TXo            out  1          serial line, idle high, registered
//   BUSYo          out  1          frame in progress
//   DONEo          out  1          one-cycle pulse at end of last stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned FREQ_CLK     = 100_000_000,
    parameter int unsigned DATA_WDTH    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned BAUD_DEFAULT = 115_200
) (
    input  logic                 CLKip,
    input  logic                 RSTi,
    input  logic [31:0]          BAUD_RATEi,
    input  logic                 BAUD_RATE_WEi,
    input  logic [DATA_WDTH-1:0] DATAi,
    input  logic                 VALIDi,
    output logic                 READYo,
    output logic                 TXo,
    output logic                 BUSYo,
    output logic                 DONEo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    localparam int unsigned BIT_W       = $clog2(DATA_WDTH + 1);
    localparam logic [31:0] FREQ        = 32'(FREQ_CLK);
    localparam logic [31:0] DIV_RAW     = 32'(FREQ_CLK / BAUD_DEFAULT);
    localparam logic [31:0] DIV_DEFAULT = (DIV_RAW == 32'd0) ? 32'd1 : DIV_RAW;
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    state_e                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_WDTH-1:0]   shift_q, shift_d;
    logic [31:0]            div_pend_q, div_pend_d;
    logic [31:0]            div_act_q, div_act_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [31:0]            baud_safe;
    logic [31:0]            quot;
    logic                   accept;
    logic                   bit_end;

    // Divisor for a new baud write. A zero rate is replaced by 1 only to keep
    // the divider defined; such a write is discarded below anyway.
    assign baud_safe = (BAUD_RATEi == 32'd0) ? 32'd1 : BAUD_RATEi;
    assign quot      = FREQ / baud_safe;
    assign accept    = VALIDi && ready_q;
    assign bit_end   = (cnt_q == div_act_q - 32'd1);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge CLKip) begin
        if (RSTi) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            div_pend_q <= DIV_DEFAULT;
            div_act_q  <= DIV_DEFAULT;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            div_pend_q <= div_pend_d;
            div_act_q  <= div_act_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;

        if (BAUD_RATEi != 32'd0 && BAUD_RATE_WEi) begin
            div_pend_d = (quot == 32'd0) ? 32'd1 : quot;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    bit_d     = '0;
                    shift_d   = DATAi;
                    // Taking the next-state pending value lets a baud write on
                    // the accept edge apply to this very frame.
                    div_act_d = div_pend_d;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: next values of the registered outputs, decoded from the
    // next state so TXo and the flags change on the same edge as the state.
    // -------------------------------------------------------------------------
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
    end

    assign TXo    = tx_q;
    assign READYo = ready_q;
    assign BUSYo  = busy_q;
    assign DONEo  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Instance dut drives the default 8N1 configuration. Every accepted word is
// pushed to a scoreboard, and a monitor checks the serial waveform cycle by
// cycle against the popped entry, decodes the word mid-bit, and checks the
// DONEo/READYo/BUSYo timing at the end of the frame. Instance dut2 uses two
// stop bits and is checked inline.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        int         bc;
        bit         abort;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] baud_i = '0;
    logic        we_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic        valid_i = 1'b0;
    logic        valid2_i = 1'b0;
    logic        ready_o, tx_o, busy_o, done_o;
    logic        ready2_o, tx2_o, busy2_o, done2_o;

    exp_t sb[$];
    int   start_log[$];
    int   done_log[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   rst_edges = 0;
    int   hs_cnt = 0;
    int   frames_done = 0;
    int   acc_cyc = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .FREQ_CLK(100_000_000), .DATA_WDTH(8), .STOP_BITS(1), .BAUD_DEFAULT(115_200)
    ) dut (
        .CLKip(clk), .RSTi(rst_i), .BAUD_RATEi(baud_i), .BAUD_RATE_WEi(we_i),
        .DATAi(data_i), .VALIDi(valid_i), .READYo(ready_o), .TXo(tx_o),
        .BUSYo(busy_o), .DONEo(done_o)
    );

    uart_tx #(
        .FREQ_CLK(100_000_000), .DATA_WDTH(8), .STOP_BITS(2), .BAUD_DEFAULT(115_200)
    ) dut2 (
        .CLKip(clk), .RSTi(rst_i), .BAUD_RATEi(baud_i), .BAUD_RATE_WEi(we_i),
        .DATAi(data_i), .VALIDi(valid2_i), .READYo(ready2_o), .TXo(tx2_o),
        .BUSYo(busy2_o), .DONEo(done2_o)
    );

    // Cycle count, reset edges and handshakes, all sampled at the active edge.
    always @(posedge clk) begin
        cyc++;
        if (rst_i) rst_edges++;
        if (!rst_i && valid_i && ready_o) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_baud(input logic [31:0] v);
        @(negedge clk);
        baud_i = v;
        we_i   = 1'b1;
        @(negedge clk);
        we_i   = 1'b0;
    endtask

    // Presents a word and returns at the first negedge after the accept edge.
    task automatic send(input logic [7:0] d, input int bc, input bit keep, input bit abort);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        @(negedge clk);
        data_i  = d;
        valid_i = 1'b1;
        for (int t = 0; t < 20000; t++) begin
            if (ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("send_ready_seen", 32'(ok), 32'd1);
        if (ok) begin
            e.data  = d;
            e.bc    = bc;
            e.abort = abort;
            sb.push_back(e);
            acc_cyc = cyc + 1;
        end
        @(negedge clk);
        if (!keep) valid_i = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int t = 0; t < budget && frames_done < target; t++) @(negedge clk);
        check("frames_completed", frames_done, target);
    endtask

    // Frame monitor for dut.
    initial begin : monitor
        exp_t       e;
        int         snap, total, bad, bit_idx, st;
        logic [7:0] rx;
        logic       expb;
        bit         aborted;
        forever begin
            @(negedge clk);
            snap = rst_edges;
            if (!rst_i && tx_o === 1'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    wait (tx_o !== 1'b0);
                end else begin
                    e       = sb.pop_front();
                    st      = cyc;
                    total   = 10 * e.bc;
                    bad     = 0;
                    rx      = '0;
                    aborted = 1'b0;
                    for (int i = 0; i < total; i++) begin
                        if (i > 0) @(negedge clk);
                        if (rst_edges != snap) begin
                            aborted = 1'b1;
                            break;
                        end
                        bit_idx = i / e.bc;
                        if (bit_idx == 0)      expb = 1'b0;
                        else if (bit_idx <= 8) expb = e.data[bit_idx-1];
                        else                   expb = 1'b1;
                        if (tx_o !== expb || done_o !== 1'b0 || busy_o !== 1'b1 || ready_o !== 1'b0)
                            bad++;
                        if (bit_idx >= 1 && bit_idx <= 8 && (i % e.bc) == e.bc / 2)
                            rx[bit_idx-1] = tx_o;
                    end
                    if (aborted) begin
                        check("abort_was_planned", 32'(e.abort), 32'd1);
                        check("tx_high_after_rst", 32'(tx_o), 32'd1);
                        check("no_done_on_rst", 32'(done_o), 32'd0);
                    end else begin
                        @(negedge clk);
                        check("frame_wave_bad_cycles", bad, 0);
                        check("loopback_data", 32'(rx), 32'(e.data));
                        check("done_pulse", 32'(done_o), 32'd1);
                        check("ready_at_done", 32'(ready_o), 32'd1);
                        check("busy_at_done", 32'(busy_o), 32'd0);
                        check("frame_not_aborted", 32'(e.abort), 32'd0);
                        start_log.push_back(st);
                        done_log.push_back(cyc);
                        frames_done++;
                    end
                end
            end
        end
    end

    initial begin : stim
        int         hs0, fd0, bad;
        logic [7:0] rx;
        logic       expb;
        bit         ok;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(ready_o), 32'd1);
        check("tx_idle", 32'(tx_o), 32'd1);

        // 1: 10 Mbaud, 0xA5, DONEo 100 cycles after accept.
        write_baud(32'd10_000_000);
        send(8'hA5, 10, 1'b0, 1'b0);
        wait_frames(1, 500);
        check("t1_done_latency", done_log[0] - acc_cyc, 100);

        // 2: VALIDi held across two frames.
        hs0 = hs_cnt;
        send(8'h00, 10, 1'b1, 1'b0);
        send(8'hFF, 10, 1'b0, 1'b0);
        wait_frames(3, 1000);
        check("t2_b2b_gap", start_log[2] - done_log[1], 1);
        check("t2_handshakes", hs_cnt - hs0, 2);

        // 3: zero baud ignored; baud above FREQ_CLK clamps to one cycle/bit.
        write_baud(32'd0);
        send(8'h3C, 10, 1'b0, 1'b0);
        wait_frames(4, 500);
        write_baud(32'd200_000_000);
        send(8'h3C, 1, 1'b0, 1'b0);
        wait_frames(5, 100);
        check("t3_len_bc1", done_log[4] - start_log[4], 10);

        // 4: baud write mid-frame affects only the following frame.
        write_baud(32'd10_000_000);
        send(8'h96, 10, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        write_baud(32'd5_000_000);
        wait_frames(6, 500);
        send(8'h69, 20, 1'b0, 1'b0);
        wait_frames(7, 1000);
        check("t4_len_old_rate", done_log[5] - start_log[5], 100);
        check("t4_len_new_rate", done_log[6] - start_log[6], 200);

        // 5: one-cycle reset inside data bit 3, then a frame at the default rate.
        fd0 = frames_done;
        send(8'hA5, 20, 1'b0, 1'b1);
        repeat (85) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("t5_ready_low_in_rst", 32'(ready_o), 32'd0);
        @(negedge clk);
        check("t5_ready_after_rst", 32'(ready_o), 32'd1);
        check("t5_busy_after_rst", 32'(busy_o), 32'd0);
        repeat (300) @(negedge clk);
        check("t5_no_done", frames_done, fd0);
        send(8'h81, 868, 1'b0, 1'b0);
        wait_frames(8, 10000);
        check("t5_len_default", done_log[7] - start_log[7], 8680);

        // 6: two stop bits on dut2, 0x55 at 10 cycles/bit.
        write_baud(32'd10_000_000);
        @(negedge clk);
        data_i   = 8'h55;
        valid2_i = 1'b1;
        ok       = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            if (ready2_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t6_ready_seen", 32'(ok), 32'd1);
        @(negedge clk);
        valid2_i = 1'b0;
        bad = 0;
        rx  = '0;
        for (int i = 0; i < 110; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 10)      expb = 1'b0;
            else if (i < 90) expb = data_i[(i / 10) - 1];
            else             expb = 1'b1;
            if (tx2_o !== expb || done2_o !== 1'b0) bad++;
            if (i >= 10 && i < 90 && (i % 10) == 5) rx[(i / 10) - 1] = tx2_o;
        end
        @(negedge clk);
        check("t6_wave_bad_cycles", bad, 0);
        check("t6_done_at_110", 32'(done2_o), 32'd1);
        check("t6_loopback", 32'(rx), 32'h55);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
